lsu_mem_resp: RTL and testbench
===============================

Name: lsu_mem_resp

Overview:
- Memory responder for the load/store port: the far end of the CPU's reqValid/respValid data interface.
- Accepts one request at a time: address, size, write enable, write data and byte mask.
- Services the request from an internal word-addressed SRAM array.
- Returns a single-cycle respValid with read data after a programmable latency. Used in simulation SoC builds and as the on-chip data RAM.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.
- LATENCY, 2, cycles from acceptance cycle to respValid cycle; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- reqValid  in  1  request strobe; sampled only in IDLE.
- addr  in  32  byte address.
- size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- wen  in  1  1=store, 0=load.
- wdata  in  32  store data, already lane-aligned.
- wmask  in  4  byte-lane enables for stores.
- respValid  out  1  one-cycle completion pulse.
- rdata  out  32  full aligned word at addr[31:2]; the requester extracts and extends.
- err  out  1  valid only with respValid; the access faulted.
- busy  out  1  high from the acceptance cycle through the respValid cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, respValid=0, rdata=0, err=0, busy=0, latency counter=0.
  - SRAM contents are not reset.
  - Reset asserted mid-operation aborts the request: no response is issued, and any write already committed remains.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - reqValid=1 accepts the request at that edge.
  - Next state is WAIT with counter=LATENCY-1; if LATENCY=1, next state is RESP.
  - busy is asserted combinationally in the acceptance cycle.
- WAIT: counter decrements each cycle; at counter==1 the next state is RESP.
- RESP: respValid=1 and busy=1 for exactly one cycle, then IDLE.
  - A new request is not accepted in the RESP cycle.
  - The earliest next acceptance is the cycle after RESP.
- reqValid while busy is ignored: no queueing, no error, no state change.
- Acceptance-edge actions:
  - addr, size, wen and the fault decision are captured.
  - A load reads SRAM[word] into the rdata hold register.
  - A store writes the lanes with wmask[i]=1 (wdata[8i+7:8i]) and sets the rdata register to 0.
  - The memory effect is therefore ordered before any later request.
- rdata holds its value after respValid until the next response. Consumers must sample only while respValid=1.
- Fault conditions (err=1 in the RESP cycle, no memory write, rdata=0):
  - (addr-BASE_ADDR) >= DEPTH*4, computed with 32-bit unsigned wrap, so addresses below BASE_ADDR also fault.
  - size==3.
  - size==1 with addr[0]=1.
  - size==2 with addr[1:0]!=0.
- A store with wmask=0 is a legal no-op store: response with err=0.
- Word index is (addr-BASE_ADDR)[log2(DEPTH)+1:2]. Accesses to the last word (offset DEPTH*4-4) are legal and must not wrap to word 0.
- Latency is exactly LATENCY cycles independent of load/store/fault.
- Back-to-back throughput is one request per LATENCY+1 cycles.

Test Plan:
- Reset and word store/load, LATENCY=2:
  - Hold reset=0 and check all outputs are 0.
  - Release reset, then store addr=0x8000_0010, size=2, wmask=4'hF, wdata=0xDEAD_BEEF. respValid must rise exactly 2 cycles after acceptance with err=0.
  - Then load the same address: rdata=0xDEAD_BEEF.
- Byte-mask store:
  - Preload word 0x1122_3344 at 0x8000_0020.
  - Store size=0, addr=0x8000_0022, wmask=4'b0100, wdata=0x00AA_0000.
  - Load word: rdata=0x11AA_3344.
- Faults, each giving err=1 with respValid after LATENCY cycles, rdata=0, and memory unchanged:
  - Word load at 0x8000_0002.
  - Load at BASE_ADDR+DEPTH*4.
  - Load at 0x7FFF_FFFC.
  - size=3.
  - Confirm a store at BASE_ADDR+DEPTH*4-4 succeeds and word 0 is untouched.
- Busy-drop:
  - Hold reqValid=1 continuously for 10 cycles with a word load.
  - Expect acceptances at cycles 0, 3, 6, 9, respValid at 2, 5, 8, and busy low only between responses.
- Reset mid-flight: accept a load, pull reset low in the WAIT state, release. Expect no respValid pulse, state IDLE, and a new request served normally.
- LATENCY=1 build: store then load back-to-back. respValid arrives 1 cycle after each acceptance and read data reflects the store.

Source files
------------

// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: load/store port memory responder with fixed response latency.
// Rev 1.0 - initial release.
`default_nettype none

module lsu_mem_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        respValid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          resp_q;
    logic          err_q;
    logic          fault_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] widx;
    logic          fault;
    logic          accept;

    // Offset uses 32-bit wrap so addresses below BASE_ADDR land out of range.
    always_comb begin
        offset = addr - BASE_ADDR;
        widx   = offset[AW+1:2];
        fault  = ({1'b0, offset} >= SPAN)
              || (size == 2'd3)
              || (size == 2'd1 && addr[0])
              || (size == 2'd2 && addr[1:0] != 2'b00);
        accept = reset && (state_q == IDLE) && reqValid;
    end

    assign busy      = accept || (state_q != IDLE);
    assign respValid = resp_q;
    assign err       = err_q;
    assign rdata     = rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        fault_q <= fault;
                        rdata_q <= (fault || wen) ? 32'd0 : mem_q[widx];
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            err_q   <= fault;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        err_q   <= fault_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stores commit at the acceptance edge, so later requests see them.
    always_ff @(posedge clock) begin
        if (accept && wen && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_resp.sv
// tb_lsu_mem_resp: checks lsu_mem_resp builds with LATENCY=2 (dut 0) and LATENCY=1 (dut 1).
`default_nettype none

module tb_lsu_mem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT0 = 2;
    localparam int          LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq   [2];
    logic [31:0] ad   [2];
    logic [1:0]  sz   [2];
    logic        we   [2];
    logic [31:0] wdt  [2];
    logic [3:0]  wmk  [2];
    logic        rv   [2];
    logic [31:0] rdt  [2];
    logic        eo   [2];
    logic        bz   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mdl0 [int];

    always #5 clk = ~clk;

    lsu_mem_resp #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(LAT0)) u_dut0 (
        .clock(clk), .reset(rst_n), .reqValid(rq[0]), .addr(ad[0]), .size(sz[0]),
        .wen(we[0]), .wdata(wdt[0]), .wmask(wmk[0]),
        .respValid(rv[0]), .rdata(rdt[0]), .err(eo[0]), .busy(bz[0])
    );

    lsu_mem_resp #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(LAT1)) u_dut1 (
        .clock(clk), .reset(rst_n), .reqValid(rq[1]), .addr(ad[1]), .size(sz[1]),
        .wen(we[1]), .wdata(wdt[1]), .wmask(wmk[1]),
        .respValid(rv[1]), .rdata(rdt[1]), .err(eo[1]), .busy(bz[1])
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request, then wait (bounded) for its response. ok=0 if busy ever dropped
    // before the response, or the cycle after it is not idle with rdata held.
    task automatic xact(input int d, input logic [31:0] a, input logic [1:0] s, input logic w,
                        input logic [31:0] wd, input logic [3:0] wm,
                        output logic [31:0] rd, output logic er, output int lat, output logic ok);
        ok = 1'b1;
        @(posedge clk); #1;
        rq[d] = 1'b1; ad[d] = a; sz[d] = s; we[d] = w; wdt[d] = wd; wmk[d] = wm;
        #1;
        if (bz[d] !== 1'b1) ok = 1'b0;
        @(posedge clk); #1;
        rq[d] = 1'b0;
        lat = 1;
        while (rv[d] !== 1'b1 && lat < 32) begin
            if (bz[d] !== 1'b1) ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rd = rdt[d];
        er = eo[d];
        if (bz[d] !== 1'b1) ok = 1'b0;
        @(posedge clk); #1;
        if (rv[d] !== 1'b0 || bz[d] !== 1'b0 || rdt[d] !== rd) ok = 1'b0;
    endtask

    // Reference behaviour of one access against the dut 0 memory model.
    task automatic ref_txn(input logic [31:0] a, input logic [1:0] s, input logic w,
                           input logic [31:0] wd, input logic [3:0] wm,
                           output logic [31:0] rd, output logic er, output logic known);
        logic [31:0] off;
        logic [31:0] m;
        int          idx;
        off   = a - BASE;
        idx   = int'(off >> 2);
        known = 1'b1;
        er    = (off >= 32'd4096) || (s == 2'd3) || (s == 2'd1 && a[0] == 1'b1)
             || (s == 2'd2 && a[1:0] != 2'b00);
        rd    = 32'd0;
        if (!er && w) begin
            m = 32'd0;
            for (int i = 0; i < 4; i++) if (wm[i]) m = m | (32'hFF << (8 * i));
            if (mdl0.exists(idx)) mdl0[idx] = (mdl0[idx] & ~m) | (wd & m);
            else if (m == 32'hFFFF_FFFF) mdl0[idx] = wd;
        end else if (!er) begin
            if (mdl0.exists(idx)) rd = mdl0[idx];
            else known = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rq[d] = 1'b0; ad[d] = '0; sz[d] = '0; we[d] = 1'b0; wdt[d] = '0; wmk[d] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rv[d] !== 1'b0 || rdt[d] !== 32'd0 || eo[d] !== 1'b0 || bz[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs d=%0d got rv=%b rdata=%h err=%b busy=%b want all 0",
                         d, rv[d], rdt[d], eo[d], bz[d]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; logic ok;
        xact(0, 32'h8000_0010, 2'd2, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ok);
        n_cmp++;
        if (lat != LAT0 || er !== 1'b0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL word_store got lat=%0d err=%b ok=%b want lat=%0d err=0 ok=1", lat, er, ok, LAT0);
        end
        xact(0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 4'h0, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != LAT0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL word_load got rdata=%h err=%b lat=%0d ok=%b want DEADBEEF 0 %0d 1", rd, er, lat, ok, LAT0);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er; int lat; logic ok;
        xact(0, 32'h8000_0020, 2'd2, 1'b1, 32'h1122_3344, 4'hF, rd, er, lat, ok);
        xact(0, 32'h8000_0022, 2'd0, 1'b1, 32'h00AA_0000, 4'b0100, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'd0 || er !== 1'b0 || lat != LAT0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_store got rdata=%h err=%b lat=%0d ok=%b want 0 0 %0d 1", rd, er, lat, ok, LAT0);
        end
        xact(0, 32'h8000_0020, 2'd2, 1'b0, 32'h0, 4'h0, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'h11AA_3344 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_load got rdata=%h err=%b want 11AA3344 0", rd, er);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic er; int lat; logic ok;
        logic [31:0] fa [5];
        logic [1:0]  fs [5];
        logic        fw [5];
        fa[0] = 32'h8000_0002; fs[0] = 2'd2; fw[0] = 1'b0;
        fa[1] = 32'h8000_1000; fs[1] = 2'd2; fw[1] = 1'b0;
        fa[2] = 32'h7FFF_FFFC; fs[2] = 2'd2; fw[2] = 1'b0;
        fa[3] = 32'h8000_0010; fs[3] = 2'd3; fw[3] = 1'b0;
        fa[4] = 32'h8000_0010; fs[4] = 2'd3; fw[4] = 1'b1;
        xact(0, 32'h8000_0000, 2'd2, 1'b1, 32'hA5A5_0000, 4'hF, rd, er, lat, ok);
        for (int i = 0; i < 5; i++) begin
            xact(0, fa[i], fs[i], fw[i], 32'h1234_5678, 4'hF, rd, er, lat, ok);
            n_cmp++;
            if (er !== 1'b1 || rd !== 32'd0 || lat != LAT0 || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_%0d addr=%h got err=%b rdata=%h lat=%0d ok=%b want 1 0 %0d 1",
                         i, fa[i], er, rd, lat, ok, LAT0);
            end
        end
        xact(0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 4'h0, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_mem_unchanged got rdata=%h err=%b want DEADBEEF 0", rd, er);
        end
        xact(0, 32'h8000_0FFC, 2'd2, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er, lat, ok);
        n_cmp++;
        if (er !== 1'b0 || lat != LAT0) begin
            n_fail++;
            $display("FAIL last_word_store got err=%b lat=%0d want 0 %0d", er, lat, LAT0);
        end
        xact(0, 32'h8000_0FFC, 2'd2, 1'b0, 32'h0, 4'h0, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word_load got rdata=%h err=%b want CAFEF00D 0", rd, er);
        end
        xact(0, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'hA5A5_0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL word0_untouched got rdata=%h err=%b want A5A50000 0", rd, er);
        end
    endtask

    // Requester holds reqValid; requests are taken whenever the responder is free.
    task automatic test_busy_drop();
        int  next_free = 0;
        int  acc_at    = -100;
        int  resp_at   = -100;
        logic exp_rv, exp_bz;
        @(posedge clk); #1;
        for (int c = 0; c < 13; c++) begin
            rq[0] = (c < 10); ad[0] = 32'h8000_0010; sz[0] = 2'd2; we[0] = 1'b0;
            wdt[0] = '0; wmk[0] = '0;
            if (c < 10 && c >= next_free) begin
                acc_at    = c;
                resp_at   = c + LAT0;
                next_free = c + LAT0 + 1;
            end
            exp_rv = (c == resp_at);
            exp_bz = (c >= acc_at && c <= resp_at);
            #1;
            n_cmp++;
            if (rv[0] !== exp_rv || bz[0] !== exp_bz || (exp_rv && rdt[0] !== 32'hDEAD_BEEF)) begin
                n_fail++;
                $display("FAIL busy_drop cycle=%0d got rv=%b busy=%b rdata=%h want rv=%b busy=%b",
                         c, rv[0], bz[0], rdt[0], exp_rv, exp_bz);
            end
            @(posedge clk); #1;
        end
        rq[0] = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; logic er; int lat; logic ok;
        int stray = 0;
        @(posedge clk); #1;
        rq[0] = 1'b1; ad[0] = 32'h8000_0020; sz[0] = 2'd2; we[0] = 1'b0;
        @(posedge clk); #1;
        rq[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rv[0] !== 1'b0 || bz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset got rv=%b busy=%b want 0 0", rv[0], bz[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (rv[0] !== 1'b0 || bz[0] !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midflight_no_resp got %0d active cycles want 0", stray);
        end
        xact(0, 32'h8000_0020, 2'd2, 1'b0, 32'h0, 4'h0, rd, er, lat, ok);
        n_cmp++;
        if (rd !== 32'h11AA_3344 || er !== 1'b0 || lat != LAT0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_recover got rdata=%h err=%b lat=%0d ok=%b want 11AA3344 0 %0d 1",
                     rd, er, lat, ok, LAT0);
        end
    endtask

    task automatic test_latency1();
        @(posedge clk); #1;
        rq[1] = 1'b1; ad[1] = 32'h8000_0040; sz[1] = 2'd2; we[1] = 1'b1;
        wdt[1] = 32'h0BAD_CAFE; wmk[1] = 4'hF;
        #1;
        n_cmp++;
        if (bz[1] !== 1'b1 || rv[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_accept got busy=%b rv=%b want 1 0", bz[1], rv[1]);
        end
        @(posedge clk); #1;
        we[1] = 1'b0; wdt[1] = '0; wmk[1] = '0;
        #1;
        n_cmp++;
        if (rv[1] !== 1'b1 || eo[1] !== 1'b0 || rdt[1] !== 32'd0 || bz[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_store_resp got rv=%b err=%b rdata=%h busy=%b want 1 0 0 1",
                     rv[1], eo[1], rdt[1], bz[1]);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (rv[1] !== 1'b0 || bz[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_second_accept got rv=%b busy=%b want 0 1", rv[1], bz[1]);
        end
        @(posedge clk); #1;
        rq[1] = 1'b0;
        #1;
        n_cmp++;
        if (rv[1] !== 1'b1 || eo[1] !== 1'b0 || rdt[1] !== 32'h0BAD_CAFE) begin
            n_fail++;
            $display("FAIL lat1_load_resp got rv=%b err=%b rdata=%h want 1 0 0BADCAFE", rv[1], eo[1], rdt[1]);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (rv[1] !== 1'b0 || bz[1] !== 1'b0 || rdt[1] !== 32'h0BAD_CAFE) begin
            n_fail++;
            $display("FAIL lat1_idle_hold got rv=%b busy=%b rdata=%h want 0 0 0BADCAFE", rv[1], bz[1], rdt[1]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic        er, eer, known, w;
        logic [1:0]  s;
        logic [3:0]  wm;
        int          lat, k;
        logic        ok;
        for (int i = 0; i < 16; i++) begin
            a  = BASE + 32'h100 + 32'(4 * i);
            wd = $urandom;
            ref_txn(a, 2'd2, 1'b1, wd, 4'hF, erd, eer, known);
            xact(0, a, 2'd2, 1'b1, wd, 4'hF, rd, er, lat, ok);
        end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3));
            else if (k == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
            else             a = BASE + 32'h100 + 32'($urandom_range(0, 63));
            s  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                if (s == 2'd2) a[1:0] = 2'b00;
                if (s == 2'd1) a[0] = 1'b0;
            end
            w  = 1'($urandom_range(0, 1));
            wm = 4'($urandom);
            wd = $urandom;
            ref_txn(a, s, w, wd, wm, erd, eer, known);
            xact(0, a, s, w, wd, wm, rd, er, lat, ok);
            n_cmp++;
            if (er !== eer || (known && rd !== erd)) begin
                n_fail++;
                $display("FAIL random_%0d addr=%h size=%0d wen=%b mask=%h got err=%b rdata=%h want err=%b rdata=%h",
                         i, a, s, w, wm, er, rd, eer, erd);
            end
            n_cmp++;
            if (lat != LAT0 || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL random_timing_%0d got lat=%0d ok=%b want lat=%0d ok=1", i, lat, ok, LAT0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_mask();
        test_faults();
        test_busy_drop();
        test_reset_midflight();
        test_latency1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
